bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 85 ++++++++
 tb/tb_bus_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - four-master round-robin bus arbiter with hold-based starvation flag
//
// Purpose: grants the bus to one of four masters. The grant is held for as
// long as the owner keeps its request low. When the owner releases, the
// search starts at the next master in round-robin order. With no request
// pending, the grant stays parked on the last owner.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high reset
//   req_n    in   [3:0] per-master request, active-low
//   grnt_n   out  [3:0] per-master grant, active-low, registered, one-cold
//   owner    out  [1:0] index of the granted master, registered
//   bus_busy out  owner is currently holding its request low
//   starve   out  a waiting master has been blocked for STARVE_LIMIT edges
module bus_arbiter #(
  parameter logic [7:0] STARVE_LIMIT = 8'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req_n,
  output logic [3:0] grnt_n,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       starve
);

  logic [1:0] next_owner;
  logic [1:0] idx;
  logic       found;
  logic       others_req;
  logic [7:0] hold_cnt;
  logic [7:0] next_hold_cnt;

  assign bus_busy = ~req_n[owner];
  assign starve   = (hold_cnt == STARVE_LIMIT);

  // Any master other than the owner currently requesting.
  assign others_req = |(~req_n & ~(4'b0001 << owner));

  // Round-robin search from owner+1. The last probe (i = 4) wraps back to
  // the owner itself, whose request is known to be high here, so an idle bus
  // stays parked on the current owner.
  always_comb begin
    next_owner = owner;
    found      = 1'b0;
    idx        = owner;
    if (req_n[owner]) begin
      for (int i = 1; i <= 4; i++) begin
        idx = owner + 2'(i);
        if (!found && !req_n[idx]) begin
          next_owner = idx;
          found      = 1'b1;
        end
      end
    end
  end

  // The hold counter measures how long the owner has kept the bus while
  // someone else waits. It saturates so that starve stays high until a
  // handoff clears it.
  always_comb begin
    next_hold_cnt = 8'd0;
    if (next_owner == owner && !req_n[owner] && others_req) begin
      if (hold_cnt == STARVE_LIMIT) begin
        next_hold_cnt = hold_cnt;
      end else begin
        next_hold_cnt = hold_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= 2'd0;
      grnt_n   <= 4'b1110;
      hold_cnt <= 8'd0;
    end else begin
      owner    <= next_owner;
      grnt_n   <= ~(4'b0001 << next_owner);
      hold_cnt <= next_hold_cnt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard testbench for bus_arbiter
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req_n;
  logic [3:0] grnt_n;
  logic [1:0] owner;
  logic       bus_busy;
  logic       starve;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] grnt;
    logic [1:0] own;
    logic       busy;
    logic       st;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  logic one_hot_en = 1'b0;

  bus_arbiter #(.STARVE_LIMIT(8'd16)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_n    (req_n),
    .grnt_n   (grnt_n),
    .owner    (owner),
    .bus_busy (bus_busy),
    .starve   (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Queue the expected outputs and signal the monitor.
  task automatic expect_now(input logic [1:0] eo, input logic eb, input logic es, input string nm);
    exp_t e;
    e.grnt = ~(4'b0001 << eo);
    e.own  = eo;
    e.busy = eb;
    e.st   = es;
    e.nm   = nm;
    exp_q.push_back(e);
    ->chk_ev;
  endtask

  // Drive req_n at the falling edge, then expect the outputs after the rising edge.
  task automatic step(input logic [3:0] req, input logic [1:0] eo, input logic eb,
                      input logic es, input string nm);
    @(negedge clk);
    req_n = req;
    @(posedge clk);
    #1;
    expect_now(eo, eb, es, nm);
  endtask

  // Monitor: pop and compare each queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (grnt_n !== e.grnt || owner !== e.own || bus_busy !== e.busy || starve !== e.st) begin
          tests_failed++;
          $display("FAIL %s: got grnt_n=%b owner=%0d bus_busy=%b starve=%b, expected grnt_n=%b owner=%0d bus_busy=%b starve=%b",
                   e.nm, grnt_n, owner, bus_busy, starve, e.grnt, e.own, e.busy, e.st);
        end
      end
    end
  end

  // Exactly one grant low at every falling edge once out of initial reset.
  always @(negedge clk) begin
    if (one_hot_en) begin
      tests_run++;
      if ($countones(~grnt_n) != 1) begin
        tests_failed++;
        $display("FAIL one_hot: got grnt_n=%b, expected exactly one bit low", grnt_n);
      end
    end
  end

  initial begin
    reset = 1'b1;
    req_n = 4'b1111;
    #2;
    expect_now(2'd0, 1'b0, 1'b0, "reset_state");
    @(negedge clk);
    reset = 1'b0;
    one_hot_en = 1'b1;

    // Idle bus stays parked on master 0.
    for (int k = 0; k < 5; k++)
      step(4'b1111, 2'd0, 1'b0, 1'b0, $sformatf("idle_%0d", k));

    // Parked bus: master 2 granted after one edge.
    step(4'b1011, 2'd2, 1'b1, 1'b0, "grant_m2");

    // Owner 2 holds with 0 and 3 waiting, then round-robin handoffs 3 then 0.
    step(4'b0010, 2'd2, 1'b1, 1'b0, "m2_hold");
    step(4'b0110, 2'd3, 1'b1, 1'b0, "handoff_m3");
    step(4'b1110, 2'd0, 1'b1, 1'b0, "handoff_m0");
    step(4'b1111, 2'd0, 1'b0, 1'b0, "park_m0");

    // Starvation: owner 1 holds while master 0 waits.
    step(4'b1101, 2'd1, 1'b1, 1'b0, "grant_m1");
    for (int k = 1; k <= 16; k++)
      step(4'b1100, 2'd1, 1'b1, (k == 16), $sformatf("starve_edge_%0d", k));
    for (int k = 0; k < 3; k++)
      step(4'b1100, 2'd1, 1'b1, 1'b1, $sformatf("starve_sat_%0d", k));
    step(4'b1110, 2'd0, 1'b1, 1'b0, "starve_clear");

    // Owner 0 re-asserts with nobody else requesting: keeps the grant.
    step(4'b1111, 2'd0, 1'b0, 1'b0, "m0_release");
    step(4'b1110, 2'd0, 1'b1, 1'b0, "m0_reacquire");

    // Asynchronous reset mid-transfer: owner 3 holding, master 1 waiting.
    step(4'b0111, 2'd3, 1'b1, 1'b0, "grant_m3");
    step(4'b0101, 2'd3, 1'b1, 1'b0, "m3_hold_m1_wait");
    #2;
    reset = 1'b1;
    #1;
    expect_now(2'd0, 1'b0, 1'b0, "async_reset");
    #1;
    reset = 1'b0;
    step(4'b0101, 2'd1, 1'b1, 1'b0, "post_reset_m1");
    step(4'b0111, 2'd3, 1'b1, 1'b0, "m1_release_m3");
    step(4'b1110, 2'd0, 1'b1, 1'b0, "m3_release_m0");

    // All masters request; each owner releases after two held edges.
    step(4'b0000, 2'd0, 1'b1, 1'b0, "rr_m0_a");
    step(4'b0000, 2'd0, 1'b1, 1'b0, "rr_m0_b");
    step(4'b0001, 2'd1, 1'b1, 1'b0, "rr_to_m1");
    step(4'b0000, 2'd1, 1'b1, 1'b0, "rr_m1_a");
    step(4'b0000, 2'd1, 1'b1, 1'b0, "rr_m1_b");
    step(4'b0010, 2'd2, 1'b1, 1'b0, "rr_to_m2");
    step(4'b0000, 2'd2, 1'b1, 1'b0, "rr_m2_a");
    step(4'b0000, 2'd2, 1'b1, 1'b0, "rr_m2_b");
    step(4'b0100, 2'd3, 1'b1, 1'b0, "rr_to_m3");
    step(4'b0000, 2'd3, 1'b1, 1'b0, "rr_m3_a");
    step(4'b0000, 2'd3, 1'b1, 1'b0, "rr_m3_b");
    step(4'b1000, 2'd0, 1'b1, 1'b0, "rr_to_m0");
    step(4'b1111, 2'd0, 1'b0, 1'b0, "final_park");

    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
